// File: rtl/pixel_feeder_pkg.sv
// Shared CNN pipeline constants and the pixel feeder reader-FSM encoding.
// Every stage of the pipeline imports this package so frame geometry stays consistent.
package pixel_feeder_pkg;

  localparam int DATA_BIT   = 8;
  localparam int IMG_WIDTH  = 28;
  localparam int IMG_HEIGHT = 28;
  localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_BIT   = 10;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_GAP    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/pixel_bank_ram.sv
// Two-bank frame store: one write port, one synchronous read port.
// The address MSB selects the bank; storage is never reset.
module pixel_bank_ram #(
  parameter int DATA_BIT   = pixel_feeder_pkg::DATA_BIT,
  parameter int NUM_PIXELS = pixel_feeder_pkg::NUM_PIXELS,
  parameter int ADDR_BIT   = pixel_feeder_pkg::ADDR_BIT
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_BIT:0]   waddr,
  input  logic [DATA_BIT-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_BIT:0]   raddr,
  output logic [DATA_BIT-1:0] rdata
);

  logic [DATA_BIT-1:0] mem [2][NUM_PIXELS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[ADDR_BIT]][waddr[ADDR_BIT-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[ADDR_BIT]][raddr[ADDR_BIT-1:0]];
  end

endmodule

// File: rtl/pixel_feeder.sv
// Ping-pong frame buffer: collects a full frame from upstream, then streams it
// out without stalls, forcing GAP_CYCLES idle cycles between output frames.
module pixel_feeder #(
  parameter int DATA_BIT   = pixel_feeder_pkg::DATA_BIT,
  parameter int IMG_WIDTH  = pixel_feeder_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = pixel_feeder_pkg::IMG_HEIGHT,
  parameter int ADDR_BIT   = pixel_feeder_pkg::ADDR_BIT,
  parameter int GAP_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_BIT-1:0]         in_data,
  output logic                        in_ready,
  output logic [DATA_BIT-1:0]         out_data,
  output logic                        out_valid,
  output logic                        frame_start,
  output logic                        frame_done,
  output pixel_feeder_pkg::rd_state_e dbg_rd_state
);
  import pixel_feeder_pkg::*;

  // Handshake: a pixel moves when in_valid && in_ready at a rising edge;
  // in_ready depends only on bank state, never on in_valid.
  localparam int                  NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(NUM_PIXELS - 1);
  localparam int                  GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  rd_state_e           state_q, state_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [ADDR_BIT-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_BIT-1:0] rd_cnt_q, rd_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                wr_en;
  logic                rd_issue;
  logic [DATA_BIT-1:0] rd_data;

  assign in_ready = ~bank_full_q[wr_bank_q];
  assign wr_en    = in_valid & in_ready;
  assign rd_issue = (state_q == RD_STREAM);

  always_comb begin
    bank_full_d   = bank_full_q;
    wr_bank_d     = wr_bank_q;
    wr_cnt_d      = wr_cnt_q;
    rd_bank_d     = rd_bank_q;
    rd_cnt_d      = rd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    state_d       = state_q;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    if (wr_en) begin
      if (wr_cnt_q == LAST_ADDR) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_cnt_d               = '0;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // Output flags are registered alongside the synchronous RAM read, so they
    // line up with the data one cycle after each address is issued.
    unique case (state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = RD_STREAM;
          rd_cnt_d = '0;
        end
      end
      RD_STREAM: begin
        out_valid_d   = 1'b1;
        frame_start_d = (rd_cnt_q == '0);
        frame_done_d  = (rd_cnt_q == LAST_ADDR);
        if (rd_cnt_q == LAST_ADDR) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          rd_cnt_d               = '0;
          gap_cnt_d              = '0;
          if (GAP_CYCLES > 0) state_d = RD_GAP;
          else if (!bank_full_q[~rd_bank_q]) state_d = RD_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      RD_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        // Leave straight for STREAM when possible so the idle gap is exactly GAP_CYCLES.
        if (gap_cnt_q == GAP_LAST) state_d = bank_full_q[rd_bank_q] ? RD_STREAM : RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      bank_full_q   <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_full_q   <= bank_full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  pixel_bank_ram #(
    .DATA_BIT  (DATA_BIT),
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_BIT  (ADDR_BIT)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wr_bank_q, wr_cnt_q}),
    .wdata(in_data),
    .re   (rd_issue),
    .raddr({rd_bank_q, rd_cnt_q}),
    .rdata(rd_data)
  );

  assign out_valid    = out_valid_q;
  assign out_data     = out_valid_q ? rd_data : '0;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign dbg_rd_state = state_q;

endmodule
